// File: rtl/mips_encode_writer_if.sv
// Request handshake and instruction-memory write bus for mips_encode_writer.
// The master drives requests and observes the writes; the slave is the encoder.
interface mips_encode_writer_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/mips_encode_writer.sv
// Encodes ALU operation requests into MIPS R/I-type words and writes them to
// consecutive instruction-memory addresses, one run of max_count words per start.
module mips_encode_writer #(
    parameter int ADDR_W = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     max_count,
    output logic [ADDR_W:0]     count,
    output logic                done,
    output logic                bad_op,
    mips_encode_writer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pointer;
    logic [ADDR_W:0]   limit;
    logic              accept;
    logic              op_ok;

    // R-type ops carry a funct code, I-type ops an opcode; rd/imm go unused accordingly.
    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm);
        logic [5:0] code;
        logic       rtype;
        code  = 6'h00;
        rtype = 1'b1;
        case (op)
            4'd0:    code = 6'h20;
            4'd1:    code = 6'h22;
            4'd2:    code = 6'h24;
            4'd3:    code = 6'h25;
            4'd4:    code = 6'h27;
            4'd5:    code = 6'h26;
            4'd6:    begin code = 6'h08; rtype = 1'b0; end
            4'd7:    begin code = 6'h0c; rtype = 1'b0; end
            4'd8:    begin code = 6'h0d; rtype = 1'b0; end
            4'd9:    begin code = 6'h0e; rtype = 1'b0; end
            default: code = 6'h00;
        endcase
        return rtype ? {6'h00, rs, rt, rd, 5'h00, code} : {code, rs, rt, imm};
    endfunction

    assign bus.in_ready = (state == RUN) && (count != limit);
    assign done         = (state == DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign op_ok        = (bus.in_op <= 4'd9);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pointer     <= '0;
            limit       <= '0;
            count       <= '0;
            bad_op      <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        pointer <= base_addr;
                        limit   <= max_count;
                        count   <= '0;
                        bad_op  <= 1'b0;
                    end
                end
                RUN: begin
                    // A zero-length run finishes here without ever raising in_ready.
                    if (count == limit) begin
                        state <= DONE;
                    end else if (accept) begin
                        if (op_ok) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= pointer;
                            bus.wr_data <= encode(bus.in_op, bus.in_rs, bus.in_rt,
                                                  bus.in_rd, bus.in_imm);
                            pointer     <= pointer + 1'b1;
                            count       <= count + 1'b1;
                            if ((count + 1'b1) == limit)
                                state <= DONE;
                        end else begin
                            bad_op <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_encode_writer.sv
// Self-checking bench for mips_encode_writer: directed scenarios plus randomized
// runs compared against a table-driven encoding model and a simple run model.
module tb_mips_encode_writer;
    localparam int ADDR_W = 10;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   max_count;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              bad_op;

    int total = 0;
    int bad   = 0;

    mips_encode_writer_if #(.ADDR_W(ADDR_W)) bus ();

    mips_encode_writer #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .max_count (max_count),
        .count     (count),
        .done      (done),
        .bad_op    (bad_op),
        .bus       (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Ops 0-5 are R-type (funct), 6-9 I-type (opcode), in op-number order.
    logic [5:0] code_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26,
                                  6'h08, 6'h0c, 6'h0d, 6'h0e};

    function automatic logic [31:0] model_enc(input int op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [4:0] rd,
                                              input logic [15:0] imm);
        if (op < 6) return {6'h00, rs, rt, rd, 5'h00, code_tab[op]};
        return {code_tab[op], rs, rt, imm};
    endfunction

    // Decoder view of a word: returns alu_op, or -1 when it would raise except.
    function automatic int model_dec(input logic [31:0] w);
        if (w[31:26] == 6'h00 && w[10:6] == 5'h00) begin
            case (w[5:0])
                6'h20: return 2;
                6'h22: return 3;
                6'h24: return 4;
                6'h25: return 5;
                6'h27: return 6;
                6'h26: return 7;
                default: return -1;
            endcase
        end
        case (w[31:26])
            6'h08: return 2;
            6'h0c: return 4;
            6'h0d: return 5;
            6'h0e: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] m);
        start = 1'b1; base_addr = b; max_count = m;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm);
        int w;
        w = 0;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt;
        bus.in_rd = rd; bus.in_imm = imm;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(posedge clock); #1; w++;
        end
        if (w >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end else begin
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
        total++; if (bus.wr_addr !== '0) begin bad++; $display("FAIL rst_wr_addr: got %h want 0", bus.wr_addr); end
        total++; if (bus.wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); end
        total++; if (count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        total++; if (done !== 1'b0 || bad_op !== 1'b0) begin bad++; $display("FAIL rst_flags: got done=%b bad_op=%b want 0 0", done, bad_op); end
        reset = 1'b0;
        @(posedge clock); #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready: got %b want 0", bus.in_ready); end
    endtask

    task automatic test_basic;
        logic [ADDR_W:0] c;
        do_start(10'h010, 11'd2);
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL basic_pre_wr_en: got %b want 0", bus.wr_en); end
        send(4'd0, 5'd8, 5'd9, 5'd10, 16'h1234);
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'h010 || bus.wr_data !== 32'h0109_5020) begin
            bad++; $display("FAIL basic_w0: got en=%b addr=%h data=%h want 1 010 01095020", bus.wr_en, bus.wr_addr, bus.wr_data); end
        send(4'd6, 5'd8, 5'd9, 5'd3, 16'hFFFF);
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'h011 || bus.wr_data !== 32'h2109_FFFF) begin
            bad++; $display("FAIL basic_w1: got en=%b addr=%h data=%h want 1 011 2109ffff", bus.wr_en, bus.wr_addr, bus.wr_data); end
        total++; if (count !== 11'd2 || done !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL basic_end: got count=%0d done=%b in_ready=%b want 2 1 0", count, done, bus.in_ready); end
        // Requests offered in DONE must be ignored.
        bus.in_valid = 1'b1; bus.in_op = 4'd1;
        c = count;
        repeat (2) @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        total++; if (bus.wr_en !== 1'b0 || count !== c || bus.wr_addr !== 10'h011) begin
            bad++; $display("FAIL done_ignore: got en=%b count=%0d addr=%h want 0 %0d 011", bus.wr_en, count, bus.wr_addr, c); end
    endtask

    task automatic test_bad_op;
        do_start(10'h100, 11'd2);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
        total++; if (bus.wr_addr !== 10'h100 || bad_op !== 1'b0) begin
            bad++; $display("FAIL bad_w0: got addr=%h bad_op=%b want 100 0", bus.wr_addr, bad_op); end
        send(4'd12, 5'd4, 5'd5, 5'd6, 16'hAAAA);
        total++; if (bus.wr_en !== 1'b0 || bad_op !== 1'b1 || count !== 11'd1 || bus.wr_addr !== 10'h100) begin
            bad++; $display("FAIL bad_op12: got en=%b bad_op=%b count=%0d addr=%h want 0 1 1 100", bus.wr_en, bad_op, count, bus.wr_addr); end
        send(4'd3, 5'd7, 5'd8, 5'd9, 16'h0);
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'h101 || bus.wr_data !== model_enc(3, 5'd7, 5'd8, 5'd9, 16'h0)) begin
            bad++; $display("FAIL bad_w1: got en=%b addr=%h data=%h want 1 101", bus.wr_en, bus.wr_addr, bus.wr_data); end
        total++; if (done !== 1'b1 || bad_op !== 1'b1) begin
            bad++; $display("FAIL bad_end: got done=%b bad_op=%b want 1 1", done, bad_op); end
    endtask

    task automatic test_wrap;
        do_start(10'h3FF, 11'd2);
        total++; if (done !== 1'b0 || bad_op !== 1'b0) begin
            bad++; $display("FAIL wrap_restart: got done=%b bad_op=%b want 0 0", done, bad_op); end
        send(4'd7, 5'd1, 5'd1, 5'd0, 16'h00FF);
        total++; if (bus.wr_addr !== 10'h3FF) begin bad++; $display("FAIL wrap_a0: got %h want 3ff", bus.wr_addr); end
        send(4'd8, 5'd2, 5'd2, 5'd0, 16'h0F0F);
        total++; if (bus.wr_addr !== 10'h000 || bus.wr_en !== 1'b1) begin
            bad++; $display("FAIL wrap_a1: got addr=%h en=%b want 000 1", bus.wr_addr, bus.wr_en); end
    endtask

    task automatic test_zero;
        bus.in_valid = 1'b1; bus.in_op = 4'd0;
        do_start(10'h055, 11'd0);
        total++; if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin
            bad++; $display("FAIL zero_run: got in_ready=%b en=%b want 0 0", bus.in_ready, bus.wr_en); end
        @(posedge clock); #1;
        total++; if (done !== 1'b1 || bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 || count !== '0) begin
            bad++; $display("FAIL zero_done: got done=%b in_ready=%b en=%b count=%0d want 1 0 0 0", done, bus.in_ready, bus.wr_en, count); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_start_ignored;
        do_start(10'h200, 11'd3);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
        do_start(10'h050, 11'd1);
        total++; if (count !== 11'd1 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL ign_start: got count=%0d done=%b in_ready=%b want 1 0 1", count, done, bus.in_ready); end
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0);
        total++; if (bus.wr_addr !== 10'h201 || count !== 11'd2) begin
            bad++; $display("FAIL ign_w1: got addr=%h count=%0d want 201 2", bus.wr_addr, count); end
        send(4'd2, 5'd4, 5'd5, 5'd6, 16'h0);
        total++; if (bus.wr_addr !== 10'h202 || done !== 1'b1) begin
            bad++; $display("FAIL ign_w2: got addr=%h done=%b want 202 1", bus.wr_addr, done); end
    endtask

    task automatic test_decode_all;
        int exp_alu [10] = '{2, 3, 4, 5, 6, 7, 2, 4, 5, 7};
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int          a;
        do_start(10'h000, 11'd10);
        for (int op = 0; op < 10; op++) begin
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
            send(4'(op), rs, rt, rd, imm);
            a = model_dec(bus.wr_data);
            total++; if (bus.wr_data !== model_enc(op, rs, rt, rd, imm) || a != exp_alu[op]) begin
                bad++; $display("FAIL dec_op%0d: got data=%h alu_op=%0d want data=%h alu_op=%0d", op, bus.wr_data, a, model_enc(op, rs, rt, rd, imm), exp_alu[op]); end
        end
    endtask

    task automatic test_random;
        for (int run = 0; run < 6; run++) begin
            int              ptr, cnt, lim, guard, op;
            logic            bflag;
            logic [4:0]      rs, rt, rd;
            logic [15:0]     imm;
            ptr = $urandom_range(1023, 0); lim = $urandom_range(8, 1);
            cnt = 0; bflag = 1'b0; guard = 0;
            do_start(10'(ptr), 11'(lim));
            while (cnt < lim && guard < 40) begin
                guard++;
                repeat ($urandom_range(2, 0)) @(posedge clock);
                #1;
                op = ($urandom_range(4, 0) == 0) ? $urandom_range(15, 10) : $urandom_range(9, 0);
                rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
                send(4'(op), rs, rt, rd, imm);
                if (op <= 9) begin
                    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'(ptr) || bus.wr_data !== model_enc(op, rs, rt, rd, imm)) begin
                        bad++; $display("FAIL rnd_write r%0d: got en=%b addr=%h data=%h want 1 %h %h", run, bus.wr_en, bus.wr_addr, bus.wr_data, 10'(ptr), model_enc(op, rs, rt, rd, imm)); end
                    ptr = (ptr + 1) % 1024; cnt++;
                end else begin
                    bflag = 1'b1;
                    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rnd_badwr r%0d: got en=%b want 0", run, bus.wr_en); end
                end
                total++; if (count !== 11'(cnt) || bad_op !== bflag) begin
                    bad++; $display("FAIL rnd_state r%0d: got count=%0d bad_op=%b want %0d %b", run, count, bad_op, cnt, bflag); end
            end
            total++; if (done !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL rnd_done r%0d: got done=%b in_ready=%b want 1 0", run, done, bus.in_ready); end
        end
    endtask

    task automatic test_reset_midrun;
        do_start(10'h020, 11'd3);
        bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd3;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL mid_pre: got en=%b want 1", bus.wr_en); end
        #1 reset = 1'b1;
        #1;
        total++; if (bus.wr_en !== 1'b0 || bus.in_ready !== 1'b0 || count !== '0 || bus.wr_addr !== '0 || bus.wr_data !== 32'h0) begin
            bad++; $display("FAIL mid_async: got en=%b in_ready=%b count=%0d addr=%h data=%h want all 0", bus.wr_en, bus.in_ready, count, bus.wr_addr, bus.wr_data); end
        #1 reset = 1'b0;
        @(posedge clock); #1;
        total++; if (bus.in_ready !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_idle: got in_ready=%b done=%b want 0 0", bus.in_ready, done); end
        do_start(10'h030, 11'd1);
        send(4'd9, 5'd3, 5'd4, 5'd0, 16'hBEEF);
        total++; if (bus.wr_addr !== 10'h030 || bus.wr_data !== 32'h3864_BEEF || done !== 1'b1) begin
            bad++; $display("FAIL mid_resume: got addr=%h data=%h done=%b want 030 3864beef 1", bus.wr_addr, bus.wr_data, done); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; max_count = '0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0;
        bus.in_rd = '0; bus.in_imm = '0;
        #1;
        test_reset();
        test_basic();
        test_bad_op();
        test_wrap();
        test_zero();
        test_start_ignored();
        test_decode_all();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_encode_writer.md
Name: mips_encode_writer

Overview:
Inverse of the arithmetic instruction decoder. Accepts operation requests (operation select, register numbers, immediate) over a valid/ready handshake. Encodes each request into a 32-bit MIPS instruction word. Writes the words to consecutive instruction-memory addresses. Used by the lab test harness and the program loader to fill instruction memory before the datapath runs.

Parameters:
ADDR_W, 10, width of the instruction-memory word address; the address pointer wraps modulo 2^ADDR_W.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
start  in  1  1-cycle pulse; loads base_addr and max_count and begins a load run
base_addr  in  ADDR_W  first write address, sampled on start
max_count  in  ADDR_W+1  number of words to write, sampled on start
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
in_op  in  4  operation: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 addi, 7 andi, 8 ori, 9 xori; 10–15 invalid
in_rs  in  5  source register
in_rt  in  5  rt (second source for R-type, destination for I-type)
in_rd  in  5  destination for R-type; ignored for I-type
in_imm  in  16  immediate for I-type; ignored for R-type
wr_en  out  1  instruction-memory write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  32  encoded instruction
count  out  ADDR_W+1  words written in current run
done  out  1  high while in DONE
bad_op  out  1  sticky; an invalid in_op was consumed in this run

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, done=0, bad_op=0. Internal pointer=0, limit=0.
- R-type encoding: {6'h00, rs, rt, rd, 5'h00, funct}.
  - Funct codes: add 6'h20, sub 6'h22, and 6'h24, or 6'h25, xor 6'h26, nor 6'h27.
- I-type encoding: {opcode, rs, rt, imm}.
  - Opcodes: addi 6'h08, andi 6'h0c, ori 6'h0d, xori 6'h0e.
  - imm is passed through unchanged; no sign or zero extension in this block.
- Every encoded word must decode in mips_decode to the originating alu_op, rd_src and alu_src2, with except=0.
- State IDLE:
  - in_ready=0.
  - start moves to RUN: pointer<=base_addr, limit<=max_count, count<=0, bad_op<=0.
- State RUN:
  - in_ready = (count != limit).
  - An accept is in_valid & in_ready.
- Accept with a valid op, at that edge:
  - wr_en<=1, wr_addr<=pointer, wr_data<=encoding.
  - pointer<=pointer+1, wrapping 2^ADDR_W-1 -> 0.
  - count<=count+1.
  - The write is visible the cycle after the accept (latency 1).
- Accept with an invalid op (10–15): the request is consumed. wr_en<=0, pointer and count unchanged, bad_op<=1.
- Any cycle without a valid-op accept: wr_en<=0. wr_addr and wr_data hold their last values.
- RUN -> DONE at the edge where count becomes limit.
  - If limit=0, the block moves to DONE on the first RUN cycle and performs no accepts.
- start while in RUN is ignored.
- State DONE:
  - done=1, in_ready=0.
  - count and bad_op hold.
  - start starts a new run exactly as from IDLE, with done falling on the next edge.
- in_valid while in_ready=0: no effect. The requester holds the request.
- Reset asserted mid-run: all outputs go to their reset values immediately, without waiting for a clock edge. A pending wr_en is dropped. Operation resumes from IDLE after reset deasserts.

Test Plan:
1. Reset asserted mid-run with wr_en=1 -> wr_en, in_ready and count go to 0 without a clock edge; state is IDLE; a start after deassert behaves normally.
2. start with base_addr=0x010, max_count=2; requests {op=0 add, rs=8, rt=9, rd=10}, then {op=6 addi, rs=8, rt=9, imm=16'hFFFF} -> wr_data 32'h0109_5020 @0x010, then 32'h2109_FFFF @0x011, each one cycle after its accept. Afterwards count=2, done=1, in_ready=0.
3. Request op=12 between two valid ops (max_count=2) -> no write for op=12; bad_op=1; the two valid words land at consecutive addresses; done after the second valid word.
4. base_addr=0x3FF, max_count=2 (ADDR_W=10) -> writes to 0x3FF then 0x000.
5. start with max_count=0 -> DONE within one cycle; in_ready is never 1; no wr_en.
6. Pulse start during RUN -> ignored; pointer and count continue. Encode each of the 10 ops and feed the words to mips_decode -> alu_op matches (2,3,4,5,6,7,2,4,5,7) and except=0 for every op.
